// File: rtl/regfile_param.sv
// Parametrised RISC-V integer register file: two combinational read ports, one
// clocked write port, and a clear sequencer that zeroes one register per cycle after reset.
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we3,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            ready,
    output logic            wr_err,
    output logic            o_dbg_state
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_clr_idx;
    logic              r_ready;
    logic              r_wr_err;
    logic [XLEN-1:0]   r_rf [NREGS];
    logic              w_x0_write;

    // A write to x0 is discarded when x0 is hardwired, and must not be forwarded either.
    assign w_x0_write = (ZERO_REG != 0) && (a3 == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_rf[r_clr_idx] <= '0;
                    r_wr_err        <= we3;
                    if (r_clr_idx == AW'(NREGS - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + AW'(1);
                    end
                end
                RUN: begin
                    r_wr_err <= 1'b0;
                    if (we3 && !w_x0_write) begin
                        r_rf[a3] <= wd3;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] v;
        v = '0;
        if (r_state == RUN) begin
            if ((ZERO_REG != 0) && (addr == '0)) begin
                v = '0;
            end else if ((BYPASS != 0) && we3 && (a3 == addr)) begin
                v = wd3;
            end else begin
                v = r_rf[addr];
            end
        end
        return v;
    endfunction

    always_comb begin
        rd1 = read_port(a1);
        rd2 = read_port(a2);
    end

    assign ready       = r_ready;
    assign wr_err      = r_wr_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations (RV32I bypass/x0, RV32I plain, RV64 16-reg)
// driven side by side and compared against an array-based model of the register file.
module tb_regfile_param;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        we_v [N];
    logic [4:0]  a1_v [N];
    logic [4:0]  a2_v [N];
    logic [4:0]  a3_v [N];
    logic [63:0] wd_v [N];

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic [63:0] rd1_w, rd2_w;
    logic        rdy_a, rdy_b, rdy_w;
    logic        err_a, err_b, err_w;
    logic        dbg_a, dbg_b, dbg_w;

    regfile_param #(.XLEN(32), .NREGS(32), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .reset(reset), .we3(we_v[0]),
        .a1(a1_v[0]), .a2(a2_v[0]), .a3(a3_v[0]), .wd3(wd_v[0][31:0]),
        .rd1(rd1_a), .rd2(rd2_a), .ready(rdy_a), .wr_err(err_a), .o_dbg_state(dbg_a)
    );

    regfile_param #(.XLEN(32), .NREGS(32), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .reset(reset), .we3(we_v[1]),
        .a1(a1_v[1]), .a2(a2_v[1]), .a3(a3_v[1]), .wd3(wd_v[1][31:0]),
        .rd1(rd1_b), .rd2(rd2_b), .ready(rdy_b), .wr_err(err_b), .o_dbg_state(dbg_b)
    );

    regfile_param #(.XLEN(64), .NREGS(16), .BYPASS(1), .ZERO_REG(1)) u_dut_w (
        .clk(clk), .reset(reset), .we3(we_v[2]),
        .a1(a1_v[2][3:0]), .a2(a2_v[2][3:0]), .a3(a3_v[2][3:0]), .wd3(wd_v[2]),
        .rd1(rd1_w), .rd2(rd2_w), .ready(rdy_w), .wr_err(err_w), .o_dbg_state(dbg_w)
    );

    // Reference model: per-instance configuration, storage and edges seen since reset.
    int          nregs_p [N] = '{32, 32, 16};
    bit          byp_p   [N] = '{1'b1, 1'b0, 1'b1};
    bit          zr_p    [N] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] mem     [N][32];
    int          cyc     [N];
    logic        exp_err [N];
    bit          model_on;

    logic [63:0] smp_rd1 [N];
    logic [63:0] smp_rd2 [N];
    logic        smp_rdy [N];
    logic        smp_err [N];

    int n_checks;
    int n_fail;
    int first_a, first_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_rd(input int i, input logic [4:0] a);
        if (cyc[i] < nregs_p[i]) return 64'd0;
        if (zr_p[i] && a == 5'd0) return 64'd0;
        if (byp_p[i] && we_v[i] && a3_v[i] == a) return wd_v[i];
        return mem[i][a];
    endfunction

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                cyc[i]     = 0;
                exp_err[i] = 1'b0;
                for (int r = 0; r < 32; r++) mem[i][r] = 64'd0;
            end else if (cyc[i] < nregs_p[i]) begin
                exp_err[i] = we_v[i];
                cyc[i]++;
            end else begin
                exp_err[i] = 1'b0;
                if (we_v[i] && !(zr_p[i] && a3_v[i] == 5'd0)) mem[i][a3_v[i]] = wd_v[i];
            end
        end
        if (reset) model_on = 1'b1;
    endtask

    // One clock: reads checked at the falling edge, registered outputs just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        smp_rd1[0] = {32'd0, rd1_a}; smp_rd2[0] = {32'd0, rd2_a};
        smp_rd1[1] = {32'd0, rd1_b}; smp_rd2[1] = {32'd0, rd2_b};
        smp_rd1[2] = rd1_w;          smp_rd2[2] = rd2_w;
        if (model_on) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("rd1[%0d] a=%0d", i, a1_v[i]), smp_rd1[i], exp_rd(i, a1_v[i]));
                check($sformatf("rd2[%0d] a=%0d", i, a2_v[i]), smp_rd2[i], exp_rd(i, a2_v[i]));
            end
        end
        @(posedge clk);
        model_edge();
        #1;
        smp_rdy[0] = rdy_a; smp_rdy[1] = rdy_b; smp_rdy[2] = rdy_w;
        smp_err[0] = err_a; smp_err[1] = err_b; smp_err[2] = err_w;
        for (int i = 0; i < N; i++) begin
            check($sformatf("ready[%0d]", i), {63'd0, smp_rdy[i]}, {63'd0, cyc[i] >= nregs_p[i]});
            check($sformatf("wr_err[%0d]", i), {63'd0, smp_err[i]}, {63'd0, exp_err[i]});
        end
    endtask

    task automatic set_all(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [4:0] a3, input logic [63:0] wd);
        for (int i = 0; i < N; i++) begin
            we_v[i] = we;
            a1_v[i] = (i == 2) ? (a1 & 5'h0f) : a1;
            a2_v[i] = (i == 2) ? (a2 & 5'h0f) : a2;
            a3_v[i] = (i == 2) ? (a3 & 5'h0f) : a3;
            wd_v[i] = (i == 2) ? wd : (wd & 64'h0000_0000_ffff_ffff);
        end
    endtask

    // Counts edges after a one-cycle reset until ready rises, bounded at 64.
    task automatic reset_and_measure();
        set_all(1'b0, 5'd0, 5'd0, 5'd0, 64'd0);
        reset = 1'b1;
        cycle();
        check("reset ready", {63'd0, smp_rdy[0]}, 64'd0);
        reset = 1'b0;
        first_a = 0;
        first_w = 0;
        for (int n = 1; n <= 64; n++) begin
            cycle();
            if (smp_rdy[0] && first_a == 0) first_a = n;
            if (smp_rdy[2] && first_w == 0) first_w = n;
        end
        check("ready edges 32x32", 64'(first_a), 64'd32);
        check("ready edges 64x16", 64'(first_w), 64'd16);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_on = 1'b0;
        for (int i = 0; i < N; i++) begin
            cyc[i]     = 0;
            exp_err[i] = 1'b0;
        end
        set_all(1'b0, 5'd0, 5'd0, 5'd0, 64'd0);
        reset = 1'b1;
        cycle();

        reset_and_measure();
        for (int r = 0; r < 32; r++) begin
            set_all(1'b0, 5'(r), 5'(31 - r), 5'd0, 64'd0);
            cycle();
            check("cleared read", smp_rd1[0], 64'd0);
        end

        set_all(1'b1, 5'd0, 5'd0, 5'd5, 64'hDEAD_BEEF);
        cycle();
        set_all(1'b0, 5'd5, 5'd5, 5'd0, 64'd0);
        cycle();
        check("x5 rd1", smp_rd1[0], 64'hDEAD_BEEF);
        check("x5 rd2", smp_rd2[0], 64'hDEAD_BEEF);

        set_all(1'b1, 5'd0, 5'd0, 5'd0, 64'h1234);
        cycle();
        set_all(1'b0, 5'd0, 5'd0, 5'd0, 64'd0);
        cycle();
        check("x0 hardwired", smp_rd1[0], 64'd0);
        check("x0 storage", smp_rd1[1], 64'h1234);

        set_all(1'b1, 5'd0, 5'd0, 5'd7, 64'h1111_1111);
        cycle();
        set_all(1'b1, 5'd7, 5'd7, 5'd7, 64'hA5A5_A5A5);
        cycle();
        check("bypass on", smp_rd1[0], 64'hA5A5_A5A5);
        check("bypass off", smp_rd1[1], 64'h1111_1111);
        set_all(1'b0, 5'd7, 5'd7, 5'd0, 64'd0);
        cycle();
        check("after bypass edge", smp_rd1[1], 64'hA5A5_A5A5);

        set_all(1'b1, 5'd0, 5'd0, 5'd15, 64'hFFFF_0000_1234_5678);
        cycle();
        set_all(1'b0, 5'd15, 5'd15, 5'd0, 64'd0);
        cycle();
        check("rv64 x15", smp_rd1[2], 64'hFFFF_0000_1234_5678);

        set_all(1'b0, 5'd3, 5'd3, 5'd3, 64'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_all(k == 10, 5'd3, 5'd3, 5'd3, 64'hCAFE);
            cycle();
            if (k == 10) check("wr_err pulse", {63'd0, smp_err[0]}, 64'd1);
            if (k == 11) check("wr_err one cycle", {63'd0, smp_err[0]}, 64'd0);
        end
        reset_and_measure();
        set_all(1'b0, 5'd3, 5'd3, 5'd0, 64'd0);
        cycle();
        check("dropped clear write", smp_rd1[0], 64'd0);

        for (int t = 0; t < 800; t++) begin
            reset = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < N; i++) begin
                we_v[i] = 1'($urandom_range(0, 1));
                a3_v[i] = 5'($urandom_range(0, nregs_p[i] - 1));
                a1_v[i] = ($urandom_range(0, 3) == 0) ? a3_v[i] : 5'($urandom_range(0, nregs_p[i] - 1));
                a2_v[i] = ($urandom_range(0, 3) == 0) ? a1_v[i] : 5'($urandom_range(0, nregs_p[i] - 1));
                wd_v[i] = (i == 2) ? {32'($urandom), 32'($urandom)} : {32'd0, 32'($urandom)};
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
